if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
Instruction-fetch stage directly upstream of the IF/ID pipeline register in the 5-stage MIPS datapath. It owns the fetch PC and issues requests to instruction memory using a req/ready handshake. A one-entry output buffer presents instr/pc4/pc8 to IF/ID, and the hazard unit stalls that buffer through en. Branch/jump redirects arrive from ID and honour the MIPS branch delay slot.

Parameters:
RESET_PC, 32'h0000_3000, fetch PC loaded on reset.
NOP_INSTR, 32'h0000_0000, instr_out value when no valid entry is presented (bubble).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
en  in  1  1 = IF/ID captures this cycle (consume); 0 = stall.
redirect  in  1  single-cycle pulse from ID: branch taken / j / jal / jr.
redirect_pc  in  32  target address, valid with redirect.
imem_req  out  1  fetch request.
imem_addr  out  32  fetch address, word aligned.
imem_ready  in  1  response strobe; may be same cycle as req (zero-wait ROM) or later.
imem_rdata  in  32  instruction word, valid when imem_ready=1.
instr_out  out  32  buffered instruction, or NOP_INSTR when invalid.
pc4_out  out  32  buffered PC+4.
pc8_out  out  32  buffered PC+8 (link address for jal).
valid_out  out  1  buffer holds a real instruction.

Behaviour:
- State registers:
  - fetch_pc: next address to fetch.
  - out_q: outstanding request; req_pc_q is its address.
  - kill_q: discard the outstanding response.
  - pend_q / pend_pc_q: deferred redirect.
  - buffer: valid_q, instr_q, pc_q.
- Reset: fetch_pc=RESET_PC. out_q, kill_q, pend_q and valid_q are 0. Outputs are instr_out=NOP_INSTR, pc4_out=0, pc8_out=0, valid_out=0, imem_req=0 during rst.
- Reset mid-transaction abandons the request. Instruction memory is reset by the same rst.
- consume = en & valid_q.
- space = !valid_q | en.
- imem_req = out_q | space.
- imem_addr = out_q ? req_pc_q : fetch_pc.
- Once raised, req and addr stay stable until imem_ready.
- Transfer (imem_req & imem_ready):
  - Not killed: buffer <= {rdata, addr}, valid_q<=1.
  - Killed: response dropped, kill_q<=0.
  - Either case: out_q<=0.
- Request not answered this cycle: out_q<=1, req_pc_q<=addr.
- fetch_pc update on a fresh launch: fetch_pc<=fetch_pc+4, or pend_pc_q if pend_q (then pend_q<=0). Wrap-around at 2^32 is modulo.
- Buffer consumed with no new load: valid_q<=0. Consume and load in the same cycle replace the entry, giving 1 instr/cycle with zero-wait memory.
- en=0 with valid_q=1: imem_req=0 unless a request is outstanding. Buffer and outputs are held.
- pc4_out=pc_q+4 and pc8_out=pc_q+8, both 32-bit modulo.
- Hazard unit guarantees redirect only when en=1; redirect with en=0 is undefined.
- Redirect rules (with DELAY_SLOT_EN):
  - valid_q=1: the buffer entry is the delay slot and is kept. This cycle's transfer, or any outstanding request, is suppressed or killed (kill_q<=1 if still outstanding). fetch_pc<=redirect_pc.
  - valid_q=0 and a request is in flight or transferring: that request is the delay slot and is kept. fetch_pc<=redirect_pc.
  - valid_q=0 and nothing in flight: fetch_pc is the delay slot address. pend_q<=1, pend_pc_q<=redirect_pc.
- Redirect coinciding with pend_q=1: the new target overwrites pend_pc_q.

Optional Feature:
DELAY_SLOT_EN.
- Defined: delay-slot rules above.
- Undefined:
  - redirect clears valid_q and kills any in-flight or transferring request.
  - fetch_pc<=redirect_pc; pend_q is never set.
  - The next instruction delivered is the one at redirect_pc.

Decomposition:
- Shared package if_pkg holds: RESET_PC default, NOP_INSTR, a word-alignment constant (2'b00), and a fetch-entry struct {valid, instr, pc}.
- One natural sub-module: fetch_buffer, the one-entry output buffer with load/consume/flush and pc4/pc8 generation.

Test Plan:
- Reset: rst pulse with RESET_PC=0x3000 -> valid_out=0, instr_out=0; first imem_addr=0x3000, imem_req=1.
- Zero-wait streaming: imem_ready tied 1, rdata=addr, en=1 -> valid every cycle; entry 0x3000 shows pc4_out=0x3004, pc8_out=0x3008; next entry 0x3004.
- Stall: en=0 for 3 cycles with valid buffer -> imem_req=0, outputs frozen; on resume no instruction lost or duplicated.
- Wait states: ready delayed 2 cycles -> req and addr 0x3008 stable; en=0 during the wait, then data accepted once.
- Redirect, buffer valid (DELAY_SLOT_EN), target 0x3100, delay slot at 0x3008 -> delivered sequence 0x3008, 0x3100; 0x300C never valid. Without the macro: next delivered is 0x3100, 0x3008 dropped.
- Redirect, buffer empty, nothing outstanding -> delay slot 0x3008 fetched, then 0x3100. Assert rst while a request is outstanding -> outputs and fetch_pc return to reset values next cycle.

Source files
------------

// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage: default reset PC,
// bubble encoding, word-alignment helper and the buffered fetch entry.
package if_pkg;

    // Fetch PC loaded on reset unless the top is overridden.
    localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_3000;

    // Instruction word presented to IF/ID when the buffer holds nothing.
    localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;

    // Low address bits of every fetch address.
    localparam logic [1:0]  WORD_ALIGN        = 2'b00;

    // One buffered instruction together with the address it came from.
    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    // Force an address onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & {{30{1'b1}}, WORD_ALIGN};
    endfunction

endpackage

// File: rtl/if_fetch_unit_buffer.sv
// One-entry output buffer in front of the IF/ID register. Holds the fetched
// instruction and its address, presents a bubble when empty, and derives the
// PC+4 / PC+8 values ID needs (PC+8 is the jal link address).
module fetch_buffer
    import if_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        consume,
    input  logic        flush,
    input  logic [31:0] load_instr,
    input  logic [31:0] load_pc,
    output logic        valid_out,
    output logic [31:0] instr_out,
    output logic [31:0] pc4_out,
    output logic [31:0] pc8_out
);

    fetch_entry_t entry_q;
    fetch_entry_t entry_d;

    // Next entry: a load replaces the entry (even when it is consumed in the
    // same cycle, which is what gives one instruction per cycle); otherwise a
    // consume or flush empties it and a stall holds it.
    always_comb begin
        entry_d = entry_q;
        if (load) begin
            entry_d.valid = 1'b1;
            entry_d.instr = load_instr;
            entry_d.pc    = load_pc;
        end else if (consume || flush) begin
            entry_d.valid = 1'b0;
        end
    end

    // Entry register, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign valid_out = entry_q.valid;
    assign instr_out = entry_q.valid ? entry_q.instr : NOP_INSTR;

    // Address outputs read as zero while reset is held; otherwise plain
    // 32-bit modulo sums so an entry at 0xFFFF_FFFC links to 0x0000_0004.
    assign pc4_out = rst ? 32'h0 : entry_q.pc + 32'd4;
    assign pc8_out = rst ? 32'h0 : entry_q.pc + 32'd8;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage feeding the IF/ID register of the 5-stage MIPS
// pipeline. Owns the fetch PC, talks to instruction memory with a req/ready
// handshake (ready may arrive in the same cycle or later), buffers one
// instruction for IF/ID and applies branch/jump redirects from ID.
//
// Build option: define DELAY_SLOT_EN to honour the MIPS branch delay slot.
// Without it a redirect squashes everything fetched after the branch and the
// next instruction delivered is the one at the target.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_out,
    output logic [31:0] pc4_out,
    output logic [31:0] pc8_out,
    output logic        valid_out
);

    // Next address to launch, and a redirect target waiting for the launch
    // of its delay slot.
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        pend_q, pend_d;
    logic [31:0] pend_pc_q, pend_pc_d;

    // Request issued but not yet answered, its address, and whether its
    // response must be thrown away when it finally arrives.
    logic        out_q, out_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        kill_q, kill_d;

    logic        valid_q;
    logic        consume;
    logic        space;
    logic        xfer;
    logic        fresh_launch;
    logic        suppress;
    logic        buf_load;
    logic        buf_flush;
    logic [31:0] target_pc;

    assign target_pc = word_align(redirect_pc);

    // IF/ID takes the entry when enabled; the buffer can accept a new word
    // when it is empty or being emptied this cycle.
    assign consume = en & valid_q;
    assign space   = !valid_q | en;

    // An outstanding request keeps req/addr stable until it is answered,
    // regardless of stalls. Nothing is requested while reset is held.
    assign imem_req  = !rst & (out_q | space);
    assign imem_addr = word_align(out_q ? req_pc_q : fetch_pc_q);

    assign xfer         = imem_req & imem_ready;
    assign fresh_launch = imem_req & !out_q;

`ifdef DELAY_SLOT_EN
    // A valid entry at redirect time is the delay slot: it leaves through the
    // normal consume, and only the word fetched after it is discarded. With
    // an empty buffer the request in flight is the delay slot and survives.
    assign suppress  = redirect & valid_q;
    assign buf_flush = 1'b0;
`else
    // Everything fetched after the branch is wrong-path.
    assign suppress  = redirect;
    assign buf_flush = redirect;
`endif

    assign buf_load = xfer & !kill_q & !suppress;

    // Request tracking: an answered request retires (its kill mark with it);
    // an unanswered one becomes outstanding and is marked for discard if a
    // redirect has made it wrong-path.
    always_comb begin
        out_d    = out_q;
        req_pc_d = req_pc_q;
        kill_d   = kill_q;
        if (xfer) begin
            out_d  = 1'b0;
            kill_d = 1'b0;
        end else if (imem_req) begin
            out_d    = 1'b1;
            req_pc_d = imem_addr;
            kill_d   = kill_q | suppress;
        end
    end

    // Fetch PC: advance on each new launch (or jump to a deferred target once
    // its delay slot has been launched); a redirect overrides the advance.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        pend_d     = pend_q;
        pend_pc_d  = pend_pc_q;
        if (fresh_launch) begin
            fetch_pc_d = pend_q ? pend_pc_q : fetch_pc_q + 32'd4;
            pend_d     = 1'b0;
        end
        if (redirect) begin
`ifdef DELAY_SLOT_EN
            if (valid_q || imem_req) begin
                // Delay slot is already buffered or requested.
                fetch_pc_d = target_pc;
                pend_d     = 1'b0;
            end else begin
                // Delay slot not yet requested: fetch_pc still points at it,
                // so park the target until that launch happens.
                pend_d    = 1'b1;
                pend_pc_d = target_pc;
            end
`else
            fetch_pc_d = target_pc;
            pend_d     = 1'b0;
`endif
        end
    end

    // Fetch-side state registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            pend_q     <= 1'b0;
            pend_pc_q  <= 32'h0;
            out_q      <= 1'b0;
            req_pc_q   <= 32'h0;
            kill_q     <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            pend_q     <= pend_d;
            pend_pc_q  <= pend_pc_d;
            out_q      <= out_d;
            req_pc_q   <= req_pc_d;
            kill_q     <= kill_d;
        end
    end

    fetch_buffer #(
        .NOP_INSTR (NOP_INSTR)
    ) u_buffer (
        .clk        (clk),
        .rst        (rst),
        .load       (buf_load),
        .consume    (consume),
        .flush      (buf_flush),
        .load_instr (imem_rdata),
        .load_pc    (imem_addr),
        .valid_out  (valid_q),
        .instr_out  (instr_out),
        .pc4_out    (pc4_out),
        .pc8_out    (pc8_out)
    );

    assign valid_out = valid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit. A program (sequential PCs with randomly placed
// branches) is turned into the expected delivered-instruction stream up
// front; a memory model answers requests with random latency, a driver
// stalls randomly and fires each branch's redirect once the branch has been
// delivered, and a monitor pops the expected stream on every delivery.
`timescale 1ns/1ps
module tb_if_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] NOP      = 32'h0000_0000;
    localparam logic [31:0] KEY      = 32'h1357_9BDF;
    localparam int          TARGET   = 160;
    localparam int          BUDGET   = 4000;
`ifdef DELAY_SLOT_EN
    localparam bit          DS       = 1'b1;
`else
    localparam bit          DS       = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr_out;
    logic [31:0] pc4_out;
    logic [31:0] pc8_out;
    logic        valid_out;

    int n_cmp = 0;
    int n_bad = 0;

    // expected delivered PCs, branch positions (delivery index) and targets
    logic [31:0] exp_q[$];
    int          br_idx[$];
    logic [31:0] br_tgt[$];

    int cnt = 0;
    int cyc = 0;
    int bi  = 0;
    bit mon_en = 1'b0;
    int min_wait = 0;
    int max_wait = 0;

    // memory model state
    bit          pending = 1'b0;
    int          age = 0;
    int          wait_left = 0;
    logic [31:0] hold_addr = 32'h0;

    if_fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .instr_out   (instr_out),
        .pc4_out     (pc4_out),
        .pc8_out     (pc8_out),
        .valid_out   (valid_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Program: sequential flow, a branch every few instructions. With the
    // delay slot the instruction after the branch is still delivered.
    task automatic build_program();
        logic [31:0] pc;
        logic [31:0] t;
        int next_br;
        int nb;
        pc = RESET_PC;
        next_br = 1;
        nb = 0;
        while (exp_q.size() < TARGET + 20) begin
            exp_q.push_back(pc);
            if (exp_q.size() - 1 == next_br) begin
                if (nb == 0)      t = 32'h0000_3100;
                else if (nb == 3) t = 32'hFFFF_FFF8;
                else              t = RESET_PC + 4 * $urandom_range(4095, 0);
                br_idx.push_back(next_br);
                br_tgt.push_back(t);
                nb++;
                if (DS) exp_q.push_back(pc + 32'd4);
                pc = t;
                next_br = exp_q.size() + int'($urandom_range(9, 3));
            end else begin
                pc = pc + 32'd4;
            end
        end
    endtask

    // Per-cycle stimulus: streaming, a 3-cycle stall, then random stalls
    // and wait states; a branch's redirect fires the cycle after delivery.
    task automatic drive_cycle();
        redirect    = 1'b0;
        redirect_pc = $urandom();
        if (cyc < 20) begin
            en = 1'b1; min_wait = 0; max_wait = 0;
        end else if (cyc < 23) begin
            en = 1'b0; min_wait = 0; max_wait = 3;
        end else begin
            en = ($urandom_range(3, 0) != 0); min_wait = 0; max_wait = 3;
        end
        if (bi < br_idx.size() && cnt == br_idx[bi] + 1) begin
            redirect    = 1'b1;
            redirect_pc = br_tgt[bi] | 32'($urandom_range(3, 0));
            en          = 1'b1;
            bi++;
        end
    endtask

    // Instruction memory: answers each request after a random number of
    // cycles, checking that req and addr are held while it waits.
    initial begin
        imem_ready = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                pending    = 1'b0;
                age        = 0;
                imem_ready = 1'b0;
                imem_rdata = 32'hDEAD_BEEF;
            end else begin
                if (pending) begin
                    check("req_held", {31'b0, imem_req}, 32'd1);
                    check("addr_stable", imem_addr, hold_addr);
                    age++;
                end else if (imem_req) begin
                    pending   = 1'b1;
                    age       = 0;
                    hold_addr = imem_addr;
                    wait_left = int'($urandom_range(max_wait, min_wait));
                end
                if (pending && wait_left == 0) begin
                    imem_ready = 1'b1;
                    imem_rdata = hold_addr ^ KEY;
                    pending    = 1'b0;
                end else begin
                    imem_ready = 1'b0;
                    imem_rdata = 32'hDEAD_BEEF;
                    if (pending) wait_left--;
                end
            end
        end
    end

    // Monitor: every delivery is compared with the next expected entry;
    // stalled cycles must hold the outputs and not request.
    initial begin
        logic [31:0] e;
        logic [31:0] snap_instr;
        logic [31:0] snap_pc4;
        bit snap_ok;
        bit redir_prev;
        bit delivered;
        snap_ok = 1'b0;
        redir_prev = 1'b0;
        snap_instr = 32'h0;
        snap_pc4 = 32'h0;
        forever begin
            @(negedge clk);
            #2;
            if (!mon_en) begin
                snap_ok = 1'b0;
                redir_prev = 1'b0;
            end else begin
                if (snap_ok) begin
                    check("hold_valid", {31'b0, valid_out}, 32'd1);
                    check("hold_instr", instr_out, snap_instr);
                    check("hold_pc4", pc4_out, snap_pc4);
                end
                if (cyc >= 1 && cyc < 20 && !redir_prev)
                    check("stream_valid", {31'b0, valid_out}, 32'd1);
                if (valid_out && !en)
                    check("stall_req", {31'b0, imem_req}, 32'd0);
                delivered = valid_out && en && !(redirect && !DS);
                if (delivered) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL deliver_extra: got pc4 %08h expected none", pc4_out);
                    end else begin
                        e = exp_q.pop_front();
                        $display("deliver %0d cyc %0d pc=%08h instr=%08h pc4=%08h pc8=%08h",
                                 cnt, cyc, e, instr_out, pc4_out, pc8_out);
                        check("deliver_instr", instr_out, e ^ KEY);
                        check("deliver_pc4", pc4_out, e + 32'd4);
                        check("deliver_pc8", pc8_out, e + 32'd8);
                    end
                    cnt++;
                end
                snap_ok    = valid_out && !en;
                snap_instr = instr_out;
                snap_pc4   = pc4_out;
                redir_prev = redirect;
            end
        end
    end

    initial begin
        bit found;
        build_program();
        rst = 1'b1;
        en = 1'b0;
        redirect = 1'b0;
        redirect_pc = 32'h0;

        // reset state
        repeat (2) @(negedge clk);
        #2;
        check("rst_valid", {31'b0, valid_out}, 32'd0);
        check("rst_instr", instr_out, NOP);
        check("rst_pc4", pc4_out, 32'h0);
        check("rst_pc8", pc8_out, 32'h0);
        check("rst_req", {31'b0, imem_req}, 32'd0);

        // main run
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        mon_en = 1'b1;
        while (cnt < TARGET && cyc < BUDGET) begin
            drive_cycle();
            if (cyc == 0) begin
                #2;
                check("first_req", {31'b0, imem_req}, 32'd1);
                check("first_addr", imem_addr, RESET_PC);
            end
            @(negedge clk);
            cyc++;
        end
        if (cnt < TARGET) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: delivered %0d expected %0d", cnt, TARGET);
        end

        // reset while a request is outstanding
        mon_en = 1'b0;
        redirect = 1'b0;
        en = 1'b1;
        min_wait = 6;
        max_wait = 6;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            #2;
            if (pending && age >= 1) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL outstanding_wait: got none expected an outstanding request");
        end
        #1;
        rst = 1'b1;
        #1;
        check("midrst_valid", {31'b0, valid_out}, 32'd0);
        check("midrst_instr", instr_out, NOP);
        check("midrst_pc4", pc4_out, 32'h0);
        check("midrst_req", {31'b0, imem_req}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        min_wait = 0;
        max_wait = 0;
        #2;
        check("postrst_req", {31'b0, imem_req}, 32'd1);
        check("postrst_addr", imem_addr, RESET_PC);
        @(negedge clk);
        #2;
        check("postrst_valid", {31'b0, valid_out}, 32'd1);
        check("postrst_instr", instr_out, RESET_PC ^ KEY);
        check("postrst_pc8", pc8_out, RESET_PC + 32'd8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
